// File: rtl/riscv_aes_ctrl_regfile.sv
// riscv_aes_ctrl_regfile
// State/key register file for the RISC-V AES unit, with multiple key slots.
// A small sequencer owns the start pulse toward the AES core and captures the core's result.
// It then holds that result for write-back to the LSU.
// Software writes are only accepted while idle. A write during an operation is dropped and flagged.
module riscv_aes_ctrl_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
    parameter int NUM_KEYS   = 2,
    parameter int KSEL_WIDTH = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          test_en_i,
    input  logic [1:0]                    instruction_sel_i,
    input  logic                          wen_i,
    input  logic [ADDR_WIDTH-1:0]         waddr_i,
    input  logic [KSEL_WIDTH-1:0]         key_slot_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          aes_start_i,
    input  logic                          res_valid_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] res_data_i,
    input  logic                          wb_ready_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] rkey_o,
    output logic [KSEL_WIDTH-1:0]         key_sel_o,
    output logic                          aes_start_o,
    output logic                          busy_o,
    output logic                          wb_valid_o,
    output logic [DATA_WIDTH-1:0]         wb_addr_o,
    output logic                          err_o
);

    localparam logic [1:0] SEL_STATE = 2'd0;
    localparam logic [1:0] SEL_KEY   = 2'd1;
    localparam logic [1:0] SEL_CTRL  = 2'd2;
    localparam logic [1:0] SEL_WBADR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   key [NUM_KEYS][NUM_WORDS];
    logic [DATA_WIDTH-1:0]   wb_addr;
    logic [KSEL_WIDTH-1:0]   key_sel;
    logic                    err;

    logic                    idle;
    logic                    wr_ok;
    logic                    slot_ok;
    logic                    addr_ok;

    // Range checks only exist when the index width can encode values past the array end
    generate
        if (NUM_KEYS == (2 ** KSEL_WIDTH)) begin : g_slot_full
            assign slot_ok = 1'b1;
        end else begin : g_slot_part
            assign slot_ok = (key_slot_i < KSEL_WIDTH'(NUM_KEYS));
        end
        if (NUM_WORDS == (2 ** ADDR_WIDTH)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (waddr_i < ADDR_WIDTH'(NUM_WORDS));
        end
    endgenerate

    assign idle  = (state == IDLE);
    assign wr_ok = idle && wen_i;

    // Sequencer plus the small control registers: key slot latch, sticky error, write-back address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_sel <= '0;
            err     <= 1'b0;
            wb_addr <= '0;
        end else if (test_en_i) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            if (wen_i && !idle) begin
                err <= 1'b1;
            end else if (wr_ok && (instruction_sel_i == SEL_CTRL)) begin
                err <= 1'b0;
            end
            if (wr_ok && (instruction_sel_i == SEL_WBADR)) begin
                wb_addr <= wdata_i;
            end
            case (state)
                IDLE: begin
                    if (aes_start_i && slot_ok) begin
                        key_sel <= key_slot_i;
                        state   <= START;
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    if (res_valid_i) begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // State block storage: software writes while idle, result capture from the core while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (test_en_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '1;
            end
        end else if ((state == BUSY) && res_valid_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (wr_ok && (instruction_sel_i == SEL_STATE) && addr_ok) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Key slot storage, written one word at a time while idle; test mode leaves keys alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    key[k][i] <= '0;
                end
            end
        end else if (!test_en_i && wr_ok && (instruction_sel_i == SEL_KEY) && slot_ok && addr_ok) begin
            key[key_slot_i][waddr_i] <= wdata_i;
        end
    end

    // Flatten the state block and the latched key slot onto the datapath buses, word 0 in the LSBs
    always_comb begin
        rdata_o = '0;
        rkey_o  = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
            rkey_o[i*DATA_WIDTH +: DATA_WIDTH]  = key[key_sel][i];
        end
    end

    assign key_sel_o   = key_sel;
    assign wb_addr_o   = wb_addr;
    assign err_o       = err;
    assign busy_o      = (state != IDLE);
    assign aes_start_o = (state == START);
    assign wb_valid_o  = (state == WB);

endmodule

// File: tb/tb_riscv_aes_ctrl_regfile.sv
// Self-checking bench for riscv_aes_ctrl_regfile.
// Expected values come from a transaction-level model made of plain arrays of words.
module tb_riscv_aes_ctrl_regfile;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int AW = 2;
    localparam int NK = 2;
    localparam int KW = 1;
    localparam int BW = NW * DW;

    logic          clk;
    logic          rst_n;
    logic          test_en_i;
    logic [1:0]    instruction_sel_i;
    logic          wen_i;
    logic [AW-1:0] waddr_i;
    logic [KW-1:0] key_slot_i;
    logic [DW-1:0] wdata_i;
    logic          aes_start_i;
    logic          res_valid_i;
    logic [BW-1:0] res_data_i;
    logic          wb_ready_i;
    logic [BW-1:0] rdata_o;
    logic [BW-1:0] rkey_o;
    logic [KW-1:0] key_sel_o;
    logic          aes_start_o;
    logic          busy_o;
    logic          wb_valid_o;
    logic [DW-1:0] wb_addr_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    // Reference model contents
    logic [DW-1:0] mem_m [NW];
    logic [DW-1:0] key_m [NK][NW];
    logic [DW-1:0] wb_addr_m;
    int            key_sel_m;

    riscv_aes_ctrl_regfile #(
        .DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDR_WIDTH(AW), .NUM_KEYS(NK), .KSEL_WIDTH(KW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
        .instruction_sel_i(instruction_sel_i), .wen_i(wen_i), .waddr_i(waddr_i),
        .key_slot_i(key_slot_i), .wdata_i(wdata_i), .aes_start_i(aes_start_i),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .wb_ready_i(wb_ready_i),
        .rdata_o(rdata_o), .rkey_o(rkey_o), .key_sel_o(key_sel_o),
        .aes_start_o(aes_start_o), .busy_o(busy_o), .wb_valid_o(wb_valid_o),
        .wb_addr_o(wb_addr_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] model_state();
        logic [BW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = mem_m[i];
        return r;
    endfunction

    function automatic logic [BW-1:0] model_key(input int slot);
        logic [BW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = key_m[slot][i];
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            mem_m[i] = '0;
            for (int k = 0; k < NK; k++) key_m[k][i] = '0;
        end
        wb_addr_m = '0;
        key_sel_m = 0;
    endtask

    // Advance to just after the next rising edge, where outputs are settled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen_i = 1'b0; aes_start_i = 1'b0; res_valid_i = 1'b0;
        wb_ready_i = 1'b0; test_en_i = 1'b0; res_data_i = '0;
    endtask

    // One-cycle software write
    task automatic sw_write(input logic [1:0] sel, input int addr, input int slot, input logic [DW-1:0] data);
        instruction_sel_i = sel; waddr_i = AW'(addr); key_slot_i = KW'(slot);
        wdata_i = data; wen_i = 1'b1;
        tick();
        wen_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        instruction_sel_i = 2'd0; waddr_i = '0; key_slot_i = '0; wdata_i = '0;
        model_reset();
        repeat (2) tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (aes_start_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b exp 0", aes_start_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wbvalid got %b exp 0", wb_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b exp 0", err_o); end
        checks++; if (rdata_o !== '0) begin errors++; $display("[TB] FAIL reset_rdata got %h exp 0", rdata_o); end
        checks++; if (rkey_o !== '0) begin errors++; $display("[TB] FAIL reset_rkey got %h exp 0", rkey_o); end
        checks++; if (key_sel_o !== '0) begin errors++; $display("[TB] FAIL reset_keysel got %h exp 0", key_sel_o); end
        checks++; if (wb_addr_o !== '0) begin errors++; $display("[TB] FAIL reset_wbaddr got %h exp 0", wb_addr_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_state_write();
        logic [DW-1:0] pattern [NW];
        pattern[0] = 32'h00112233; pattern[1] = 32'h44556677;
        pattern[2] = 32'h8899AABB; pattern[3] = 32'hCCDDEEFF;
        for (int i = 0; i < NW; i++) begin
            sw_write(2'd0, i, 0, pattern[i]);
            mem_m[i] = pattern[i];
            checks++; if (rdata_o !== model_state()) begin errors++; $display("[TB] FAIL state_write%0d got %h exp %h", i, rdata_o, model_state()); end
        end
        for (int n = 0; n < 6; n++) begin
            int a;
            logic [DW-1:0] d;
            a = $urandom_range(NW - 1);
            d = $urandom;
            sw_write(2'd0, a, 0, d);
            mem_m[a] = d;
            checks++; if (rdata_o !== model_state()) begin errors++; $display("[TB] FAIL state_rand%0d got %h exp %h", n, rdata_o, model_state()); end
        end
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("[TB] FAIL state_flags got busy=%b err=%b exp 0 0", busy_o, err_o); end
    endtask

    task automatic test_key_write();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < NW; i++) begin
                logic [DW-1:0] d;
                d = $urandom;
                sw_write(2'd1, i, k, d);
                key_m[k][i] = d;
            end
            checks++; if (rkey_o !== model_key(key_sel_m)) begin errors++; $display("[TB] FAIL key_write_slot%0d got %h exp %h", k, rkey_o, model_key(key_sel_m)); end
        end
        wb_addr_m = $urandom;
        sw_write(2'd3, 0, 0, wb_addr_m);
        checks++; if (wb_addr_o !== wb_addr_m) begin errors++; $display("[TB] FAIL wbaddr_write got %h exp %h", wb_addr_o, wb_addr_m); end
        instruction_sel_i = 2'd3; wdata_i = ~wb_addr_m; wen_i = 1'b0;
        tick();
        checks++; if (wb_addr_o !== wb_addr_m) begin errors++; $display("[TB] FAIL wbaddr_nowen got %h exp %h", wb_addr_o, wb_addr_m); end
    endtask

    task automatic test_operation();
        logic [BW-1:0] result;
        aes_start_i = 1'b1; key_slot_i = 1'b1;
        tick();
        aes_start_i = 1'b0;
        key_sel_m = 1;
        checks++; if (aes_start_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse got start=%b busy=%b exp 1 1", aes_start_o, busy_o); end
        checks++; if (key_sel_o !== KW'(key_sel_m)) begin errors++; $display("[TB] FAIL start_keysel got %0d exp %0d", key_sel_o, key_sel_m); end
        checks++; if (rkey_o !== model_key(key_sel_m)) begin errors++; $display("[TB] FAIL start_rkey got %h exp %h", rkey_o, model_key(key_sel_m)); end
        tick();
        checks++; if (aes_start_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL start_width got start=%b busy=%b exp 0 1", aes_start_o, busy_o); end
        sw_write(2'd0, 0, 0, 32'hDEADBEEF);
        checks++; if (err_o !== 1'b1 || rdata_o !== model_state()) begin errors++; $display("[TB] FAIL busy_write got err=%b data=%h exp 1 %h", err_o, rdata_o, model_state()); end
        sw_write(2'd2, 0, 0, '0);
        checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL busy_clear got %b exp 1", err_o); end
        aes_start_i = 1'b1;
        tick();
        aes_start_i = 1'b0;
        checks++; if (aes_start_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL busy_restart got start=%b busy=%b exp 0 1", aes_start_o, busy_o); end
        result = rand_block();
        res_valid_i = 1'b1; res_data_i = result;
        tick();
        res_valid_i = 1'b0; res_data_i = '0;
        for (int i = 0; i < NW; i++) mem_m[i] = result[i*DW +: DW];
        checks++; if (rdata_o !== model_state()) begin errors++; $display("[TB] FAIL result_capture got %h exp %h", rdata_o, model_state()); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (wb_valid_o !== 1'b1 || wb_addr_o !== wb_addr_m || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL wb_hold%0d got v=%b a=%h exp 1 %h", c, wb_valid_o, wb_addr_o, wb_addr_m); end
            tick();
        end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL wb_done got busy=%b v=%b exp 0 0", busy_o, wb_valid_o); end
        sw_write(2'd2, 0, 0, '0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_clear got %b exp 0", err_o); end
        res_valid_i = 1'b1; res_data_i = rand_block(); wb_ready_i = 1'b1;
        tick();
        idle_inputs();
        checks++; if (rdata_o !== model_state() || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore got %h busy=%b exp %h 0", rdata_o, busy_o, model_state()); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            int slot;
            int a;
            logic [DW-1:0] d;
            logic [BW-1:0] result;
            slot = $urandom_range(NK - 1);
            a = $urandom_range(NW - 1);
            d = $urandom;
            // write and start in the same idle cycle; the core must see the new word at START
            aes_start_i = 1'b1; key_slot_i = KW'(slot);
            instruction_sel_i = 2'd0; waddr_i = AW'(a); wdata_i = d; wen_i = 1'b1;
            tick();
            aes_start_i = 1'b0; wen_i = 1'b0;
            mem_m[a] = d; key_sel_m = slot;
            checks++; if (aes_start_o !== 1'b1 || rdata_o !== model_state()) begin errors++; $display("[TB] FAIL b2b_start%0d got s=%b d=%h exp 1 %h", n, aes_start_o, rdata_o, model_state()); end
            checks++; if (key_sel_o !== KW'(slot) || rkey_o !== model_key(slot)) begin errors++; $display("[TB] FAIL b2b_key%0d got %0d %h exp %0d %h", n, key_sel_o, rkey_o, slot, model_key(slot)); end
            // a result strobe during START is not accepted
            res_valid_i = 1'b1; res_data_i = rand_block();
            tick();
            checks++; if (wb_valid_o !== 1'b0 || rdata_o !== model_state()) begin errors++; $display("[TB] FAIL b2b_early%0d got v=%b d=%h exp 0 %h", n, wb_valid_o, rdata_o, model_state()); end
            result = rand_block();
            res_data_i = result;
            tick();
            res_valid_i = 1'b0;
            for (int i = 0; i < NW; i++) mem_m[i] = result[i*DW +: DW];
            checks++; if (wb_valid_o !== 1'b1 || rdata_o !== model_state()) begin errors++; $display("[TB] FAIL b2b_result%0d got v=%b d=%h exp 1 %h", n, wb_valid_o, rdata_o, model_state()); end
            wb_ready_i = 1'b1;
            tick();
            wb_ready_i = 1'b0;
            checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle%0d got %b exp 0", n, busy_o); end
        end
    endtask

    task automatic test_reset_midop();
        aes_start_i = 1'b1; key_slot_i = 1'b1;
        tick();
        aes_start_i = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (busy_o !== 1'b0 || aes_start_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midop_flags got %b%b%b exp 000", busy_o, aes_start_o, wb_valid_o); end
        checks++; if (rdata_o !== '0 || rkey_o !== '0 || key_sel_o !== '0 || wb_addr_o !== '0) begin errors++; $display("[TB] FAIL midop_storage got %h %h exp 0 0", rdata_o, rkey_o); end
        tick();
        rst_n = 1'b1;
        tick();
        res_valid_i = 1'b1; res_data_i = rand_block();
        tick();
        res_valid_i = 1'b0;
        tick();
        checks++; if (rdata_o !== '0 || wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midop_stale got %h v=%b exp 0 0", rdata_o, wb_valid_o); end
    endtask

    task automatic test_testmode();
        for (int i = 0; i < NW; i++) begin
            key_m[1][i] = $urandom;
            sw_write(2'd1, i, 1, key_m[1][i]);
        end
        wb_addr_m = $urandom;
        sw_write(2'd3, 0, 0, wb_addr_m);
        aes_start_i = 1'b1; key_slot_i = 1'b1;
        tick();
        aes_start_i = 1'b0;
        key_sel_m = 1;
        tick();
        sw_write(2'd0, 1, 0, $urandom);
        res_valid_i = 1'b1; res_data_i = rand_block();
        tick();
        res_valid_i = 1'b0;
        checks++; if (wb_valid_o !== 1'b1 || err_o !== 1'b1) begin errors++; $display("[TB] FAIL tm_setup got v=%b e=%b exp 1 1", wb_valid_o, err_o); end
        test_en_i = 1'b1;
        tick();
        test_en_i = 1'b0;
        for (int i = 0; i < NW; i++) mem_m[i] = '1;
        checks++; if (rdata_o !== model_state()) begin errors++; $display("[TB] FAIL tm_rdata got %h exp %h", rdata_o, model_state()); end
        checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("[TB] FAIL tm_flags got b=%b v=%b e=%b exp 000", busy_o, wb_valid_o, err_o); end
        checks++; if (key_sel_o !== KW'(key_sel_m) || rkey_o !== model_key(key_sel_m)) begin errors++; $display("[TB] FAIL tm_key got %0d %h exp %0d %h", key_sel_o, rkey_o, key_sel_m, model_key(key_sel_m)); end
        checks++; if (wb_addr_o !== wb_addr_m) begin errors++; $display("[TB] FAIL tm_wbaddr got %h exp %h", wb_addr_o, wb_addr_m); end
    endtask

    initial begin
        test_reset();
        test_state_write();
        test_key_write();
        test_operation();
        test_back_to_back();
        test_reset_midop();
        test_testmode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_aes_ctrl_regfile.md
# riscv_aes_ctrl_regfile

Parametrised successor of the AES register file: a flip-flop state/key store that adds multiple key slots, a sequencing FSM, result capture from the AES core and a write-back handshake toward the LSU. It sits between the RISC-V AES instruction decode (write side) and the AES datapath (read side). It owns `aes_start` generation and busy/error status, so software cannot corrupt operands mid-operation.

## Interface
- DATA_WIDTH, 32, width of one word
- NUM_WORDS, 4, state words per block (block = NUM_WORDS*DATA_WIDTH bits)
- ADDR_WIDTH, $clog2(NUM_WORDS), word address width
- NUM_KEYS, 2, number of key slots (≥1)
- KSEL_WIDTH, max(1,$clog2(NUM_KEYS)), key slot index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- test_en_i  in  1  test mode
- instruction_sel_i  in  2  0 = state write, 1 = key write, 2 = control (clear error), 3 = wb address write
- wen_i  in  1  write strobe
- waddr_i  in  ADDR_WIDTH  word address
- key_slot_i  in  KSEL_WIDTH  key slot for key writes and for start
- wdata_i  in  DATA_WIDTH  write data
- aes_start_i  in  1  start request
- res_valid_i  in  1  AES core result valid (single-cycle)
- res_data_i  in  NUM_WORDS*DATA_WIDTH  result block, word 0 in LSBs
- wb_ready_i  in  1  write-back consumer ready
- rdata_o  out  NUM_WORDS*DATA_WIDTH  state block, word 0 in LSBs
- rkey_o  out  NUM_WORDS*DATA_WIDTH  key of latched slot
- key_sel_o  out  KSEL_WIDTH  latched key slot
- aes_start_o  out  1  one-cycle start pulse to core
- busy_o  out  1  FSM not IDLE
- wb_valid_o  out  1  result ready for write-back
- wb_addr_o  out  DATA_WIDTH  write-back address
- err_o  out  1  sticky write-while-busy error

## Operation
- Storage: mem[NUM_WORDS], key[NUM_KEYS][NUM_WORDS], wb_addr, key_sel, err; all reset to 0. FSM resets to IDLE.
- FSM states:
  - IDLE: writes accepted; aes_start_i=1 → latch key_sel ← key_slot_i, go START.
  - START: aes_start_o=1; → BUSY unconditionally.
  - BUSY: on res_valid_i=1 → mem ← res_data_i, go WB.
  - WB: wb_valid_o=1; on wb_ready_i=1 → IDLE.
- Writes in IDLE with wen_i=1:
  - sel 0: mem[waddr_i] ← wdata_i.
  - sel 1: key[key_slot_i][waddr_i] ← wdata_i; key_slot_i ≥ NUM_KEYS → write dropped.
  - sel 2: err ← 0.
  - sel 3: wb_addr ← wdata_i. Unlike the predecessor, wen_i is required.
- wen_i=1 in any non-IDLE state: write dropped, err ← 1. Sel 2 is also dropped there; err can only be cleared in IDLE.
- aes_start_i outside IDLE: ignored, no error. aes_start_i with slot ≥ NUM_KEYS: start ignored.
- res_valid_i outside BUSY: ignored. wb_ready_i outside WB: ignored.
- Same cycle in IDLE with wen_i and aes_start_i both set: write and start both take effect. The core sees the written value at START.
- test_en_i=1 overrides all: mem ← all ones, FSM → IDLE, err ← 0. Key, wb_addr and key_sel are held.
- Reset mid-operation: all state and outputs return to reset values asynchronously. No pending start or write-back survives.

## Timing
- All outputs are registered or decoded from registered state, with no combinational path from inputs:
  - busy_o = (state != IDLE)
  - aes_start_o = (state == START)
  - wb_valid_o = (state == WB)
- Reset value of every output is 0, except rdata_o and rkey_o, which are 0 through storage reset.
- Start request sampled at edge N → aes_start_o and busy_o high in cycle N+1. aes_start_o lasts exactly 1 cycle.
- res_valid_i sampled at edge M → rdata_o shows the result and wb_valid_o rises in cycle M+1.
- wb_valid_o and wb_addr_o are held stable until wb_ready_i is sampled high. busy_o falls the cycle after.
- Minimum start-to-start interval is 4 cycles (START, BUSY, WB, IDLE) when the result and ready arrive immediately.
- Write latency: a register write is visible on its output the cycle after wen_i is sampled.

## Test plan
- Reset, then write mem words 0..3 = 0x00112233..0xCCDDEEFF with sel 0 → rdata_o matches; busy_o=0, err_o=0.
- Load key slot 1 (sel 1, key_slot_i=1), then start with key_slot_i=1 → key_sel_o=1, rkey_o = slot-1 key, aes_start_o single pulse one cycle after request.
- In BUSY, issue a sel 0 write of 0xDEADBEEF → mem unchanged, err_o=1. A sel 2 write after return to IDLE → err_o=0.
- Drive res_valid_i with a 128-bit result and hold wb_ready_i=0 for 3 cycles → rdata_o = result, wb_valid_o high 3+ cycles with wb_addr_o stable; ready → IDLE next cycle.
- Assert rst_n low during BUSY → busy_o, aes_start_o, wb_valid_o and all storage read 0 immediately. A later res_valid_i is ignored.
- test_en_i=1 during WB → rdata_o all ones, FSM IDLE, key contents retained.
